// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the gated-window frequency meter.
// The FSM state enum is also the type of the top-level debug state output.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int ARM_CYCLES       = 2;
  localparam int DEF_GATE_CYCLES  = 1000000;
  localparam int DEF_CNT_W        = 20;
  localparam int DEF_MIN_CNT      = 0;
  localparam int DEF_LOCK_WINDOWS = 4;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// A rise on async_in appears as a one-cycle pulse on rise three clocks later.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over back-to-back gate windows
// of GATE_CYCLES clocks and reports count, overflow, range and lock status.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int MIN_CNT      = DEF_MIN_CNT,
  parameter int MAX_CNT      = 2**CNT_W - 2,
  parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_in,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow,
  output logic             in_range,
  output logic             locked,
  output state_t           dbg_state
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int LW = $clog2(LOCK_WINDOWS + 1);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0]    ARM_LAST  = GW'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT       = '1;
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CNT);
  localparam logic [LW-1:0]    LOCK_C    = LW'(LOCK_WINDOWS);

  state_t           state, state_nxt;
  logic             rise;
  logic             win_done, abort;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_nxt;
  logic [LW-1:0]    lock_cnt, lock_nxt;
  logic             min_ok, win_ovf, win_in_range;

  sync_edge u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (meas_in),
    .rise     (rise)
  );

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ARM reuses the gate counter to time the pipeline fill.
  always_comb begin
    state_nxt = state;
    win_done  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = ARM;
      end
      ARM: begin
        if (!enable) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (gate_cnt == ARM_LAST) begin
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (gate_cnt == GATE_LAST) begin
          win_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window result includes an edge arriving on the final gate cycle.
  always_comb begin
    edge_nxt = edge_cnt;
    if (rise && (edge_cnt != SAT)) edge_nxt = edge_cnt + 1'b1;
  end

  assign win_ovf = (edge_nxt == SAT);

  if (MIN_CNT == 0) begin : g_min_zero
    assign min_ok = 1'b1;
  end else begin : g_min
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CNT);
    assign min_ok = (edge_nxt >= MIN_C);
  end

  assign win_in_range = !win_ovf && min_ok && (edge_nxt <= MAX_C);

  always_comb begin
    lock_nxt = '0;
    if (win_in_range) lock_nxt = (lock_cnt == LOCK_C) ? lock_cnt : lock_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
      in_range    <= 1'b0;
      lock_cnt    <= '0;
      locked      <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (abort) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end
      case (state)
        ARM: begin
          gate_cnt <= (state_nxt == ARM) ? gate_cnt + 1'b1 : '0;
          edge_cnt <= '0;
        end
        MEASURE: begin
          if (abort) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
          end else if (win_done) begin
            // Delivery cycle is also gate cycle 0 of the next window.
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            count       <= edge_nxt;
            overflow    <= win_ovf;
            in_range    <= win_in_range;
            count_valid <= 1'b1;
            lock_cnt    <= lock_nxt;
            locked      <= (lock_nxt == LOCK_C);
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_nxt;
          end
        end
        default: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Randomised bench for freq_meter: two instances (8-bit narrow-range, 4-bit
// saturating) share stimulus; a window-level reference model feeds expectations.
module tb_freq_meter;
  import freq_meter_pkg::*;

  localparam int G    = 100;
  localparam int W    = 43;
  localparam int LOCK = 4;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic meas_in = 1'b0;
  logic enable  = 1'b0;

  logic [7:0] a_count;
  logic       a_valid, a_ovf, a_inr, a_lock;
  state_t     a_state;
  logic [3:0] b_count;
  logic       b_valid, b_ovf, b_inr, b_lock;
  state_t     b_state;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .MIN_CNT(9), .MAX_CNT(11), .LOCK_WINDOWS(LOCK)) dut_a (
    .clk(clk), .rst_n(rst_n), .meas_in(meas_in), .enable(enable),
    .count(a_count), .count_valid(a_valid), .overflow(a_ovf), .in_range(a_inr),
    .locked(a_lock), .dbg_state(a_state)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .LOCK_WINDOWS(LOCK)) dut_b (
    .clk(clk), .rst_n(rst_n), .meas_in(meas_in), .enable(enable),
    .count(b_count), .count_valid(b_valid), .overflow(b_ovf), .in_range(b_inr),
    .locked(b_lock), .dbg_state(b_state)
  );

  // Clock and cycle index: values seen after posedge n belong to cycle n.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state.
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // Reference model state.
  int cw[2]     = '{8, 4};
  int minc[2]   = '{9, 0};
  int maxc[2]   = '{11, 14};
  int lock_c[2] = '{0, 0};
  int held[2]   = '{0, 0};
  bit active    = 1'b0;
  int ws        = 0;
  bit prev_meas = 1'b0;
  int rises[$];
  int ph        = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Window-level model: an input rise in cycle k is seen by the counter in
  // cycle k+3; a window spans G cycles starting 3 cycles after enable is seen.
  task automatic model_step(input bit en, input bit m, input int c);
    int n, sat, cnt;
    bit ovf, inr, lk;
    if (m && !prev_meas) rises.push_back(c + 3);
    prev_meas = m;
    if (!rst_n) begin
      active = 1'b0;
      lock_c = '{0, 0};
      held   = '{0, 0};
      rises.delete();
      return;
    end
    if (active) begin
      if (!en) begin
        active = 1'b0;
        lock_c = '{0, 0};
      end else if (c == ws + G - 1) begin
        n = 0;
        while (rises.size() > 0 && rises[0] < ws) void'(rises.pop_front());
        while (rises.size() > 0 && rises[0] <= c) begin
          n++;
          void'(rises.pop_front());
        end
        for (int i = 0; i < 2; i++) begin
          sat = (1 << cw[i]) - 1;
          cnt = (n > sat) ? sat : n;
          ovf = (cnt == sat);
          inr = !ovf && (cnt >= minc[i]) && (cnt <= maxc[i]);
          lock_c[i] = inr ? ((lock_c[i] < LOCK) ? lock_c[i] + 1 : LOCK) : 0;
          lk = (lock_c[i] == LOCK);
          held[i] = cnt;
          if (i == 0) exp_q0.push_back({32'(c + 1), 8'(cnt), ovf, inr, lk});
          else        exp_q1.push_back({32'(c + 1), 8'(cnt), ovf, inr, lk});
        end
        ws = ws + G;
      end
    end else if (en) begin
      active = 1'b1;
      ws     = c + 3;
    end
  endtask

  // Driver tasks.
  task automatic next_meas(input int period, output bit m);
    ph = ph % period;
    m  = (ph < period / 2);
    ph = (ph + 1) % period;
  endtask

  task automatic tick(input bit en, input bit m);
    @(negedge clk);
    enable  = en;
    meas_in = m;
    model_step(en, m, cyc);
  endtask

  task automatic run(input int period, input int n, input bit en, input bit rnd);
    bit m, e;
    int off;
    off = 0;
    for (int k = 0; k < n; k++) begin
      next_meas(period, m);
      e = en;
      if (rnd) begin
        if (off > 0) begin
          e = 1'b0;
          off--;
        end else if ($urandom_range(0, 149) == 0) begin
          e   = 1'b0;
          off = $urandom_range(1, 4);
        end
      end
      tick(e, m);
    end
  endtask

  task automatic gate_wait(input int g, input int period);
    bit m;
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 3 * G; k++) begin
      if (cyc + 1 == ws + g) begin
        hit = 1'b1;
        break;
      end
      next_meas(period, m);
      tick(1'b1, m);
    end
    check("gate_wait_reached", int'(hit), 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_a_count", int'(a_count), 0);
    check("rst_a_valid", int'(a_valid), 0);
    check("rst_a_ovf",   int'(a_ovf),   0);
    check("rst_a_inr",   int'(a_inr),   0);
    check("rst_a_lock",  int'(a_lock),  0);
    check("rst_a_state", int'(a_state), int'(IDLE));
    check("rst_b_count", int'(b_count), 0);
    check("rst_b_valid", int'(b_valid), 0);
    check("rst_b_ovf",   int'(b_ovf),   0);
    check("rst_b_inr",   int'(b_inr),   0);
    check("rst_b_lock",  int'(b_lock),  0);
    check("rst_b_state", int'(b_state), int'(IDLE));
  endtask

  // Monitor: pops one expectation per count_valid pulse.
  task automatic mon(input int i, input logic v, input int cnt, input logic ovf,
                     input logic inr, input logic lk);
    logic [W-1:0] e;
    if (!v) return;
    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_valid dut%0d: count_valid=1 at cycle %0d, required no pulse", i, cyc);
      return;
    end
    if (i == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
    check($sformatf("valid_cycle_dut%0d", i), cyc, int'(e[42:11]));
    check($sformatf("count_dut%0d", i), cnt, int'(e[10:3]));
    check($sformatf("overflow_dut%0d", i), int'(ovf), int'(e[2]));
    check($sformatf("in_range_dut%0d", i), int'(inr), int'(e[1]));
    check($sformatf("locked_dut%0d", i), int'(lk), int'(e[0]));
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, a_valid, int'(a_count), a_ovf, a_inr, a_lock);
    mon(1, b_valid, int'(b_count), b_ovf, b_inr, b_lock);
  end

  initial begin
    bit m;
    // Reset with the measured input toggling.
    #2 rst_n = 1'b0;
    for (int k = 0; k < 8; k++) tick(1'b0, k[0]);
    #1 check_reset_outputs();
    tick(1'b0, 1'b0);
    rst_n = 1'b1;
    run(10, 105, 1'b0, 1'b0);

    // Steady period 10: lock on the 4th window for the narrow-range instance.
    ph = $urandom_range(0, 9);
    run(10, 3 + 6 * G, 1'b1, 1'b0);
    // Slower input drops out of range; faster input saturates the 4-bit counter.
    run(20, 2 * G, 1'b1, 1'b0);
    run(4, 2 * G, 1'b1, 1'b0);

    // Relock, then abort at gate cycle 50.
    run(10, 5 * G, 1'b1, 1'b0);
    gate_wait(50, 10);
    for (int k = 0; k < 5; k++) begin
      next_meas(10, m);
      tick(1'b0, m);
    end
    check("abort_a_locked", int'(a_lock), 0);
    check("abort_b_locked", int'(b_lock), 0);
    check("abort_a_count_hold", int'(a_count), held[0]);
    check("abort_b_count_hold", int'(b_count), held[1]);

    // Re-enable for two windows, dropping enable on the delivery cycle.
    run(10, 3 + 2 * G, 1'b1, 1'b0);
    next_meas(10, m);
    tick(1'b0, m);
    run(10, 20, 1'b0, 1'b0);

    // Asynchronous reset in gate cycle 60.
    run(10, 63, 1'b1, 1'b0);
    @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    #1 check_reset_outputs();
    run(10, 5, 1'b0, 1'b0);
    rst_n = 1'b1;
    run(10, 10, 1'b0, 1'b0);

    // Random periods with occasional enable drops.
    for (int p = 0; p < 10; p++) begin
      run($urandom_range(2, 25), $urandom_range(50, 350), 1'b1, 1'b1);
    end

    run(10, 12, 1'b0, 1'b0);
    check("exp_q0_drained", int'(exp_q0.size()), 0);
    check("exp_q1_drained", int'(exp_q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
